// File: rtl/uart_bootloader.sv
// UART-to-SPI bridge for the bootloader image: the host frames SPI transfers
// against the configuration flash over an 8N1 link and can trigger a warm boot.
module uart_bootloader #(
    parameter int CLK_FREQ      = 12000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int SPI_HALF      = 6,
    parameter int BREAK_BITS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       spi_sck,
    output logic       spi_so,
    input  logic       spi_si,
    output logic       spi_ss,
    output logic       boot,
    output logic [1:0] boot_sel
);

    localparam int P         = CLK_FREQ / UART_BAUDRATE;
    localparam int BREAK_CYC = BREAK_BITS * P;
    localparam int BW        = $clog2(P + 1);
    localparam int KW        = $clog2(BREAK_CYC + 1);
    localparam int SW        = $clog2(SPI_HALF + 1);

    typedef enum logic [2:0] {
        IDLE, TXL0, TXL1, RXL0, RXL1, TXDATA, RXDATA, BOOTED
    } state_t;

    state_t state, state_n;

    logic          rx_s1, rx_s2, rx_s3;
    logic [KW-1:0] brk_cnt;
    logic          brk;

    logic          rx_busy, rx_valid;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic [7:0]    rx_shift;

    logic          tx_busy, tx_start;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [8:0]    tx_sr;

    logic          spi_busy, spi_start, spi_done;
    logic [7:0]    spi_byte;
    logic [SW-1:0] spi_cnt;
    logic [3:0]    spi_edges;
    logic [6:0]    sr_o;
    logic [7:0]    sr_i;

    logic          ss_fall, ss_end, hold_busy;
    logic [SW-1:0] hold_cnt;

    logic [15:0]   tx_len, tx_len_n, rx_len, rx_len_n;

    assign boot     = (state == BOOTED);
    assign boot_sel = 2'b01;

    // Break is a long run of low samples; it fires once per low period.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            brk_cnt <= '0;
            brk     <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            brk   <= !rx_s2 && (brk_cnt == KW'(BREAK_CYC - 1));
            if (rx_s2)
                brk_cnt <= '0;
            else if (brk_cnt != KW'(BREAK_CYC))
                brk_cnt <= brk_cnt + 1'b1;
        end
    end

    // Receiver: start detected on a falling edge, so after a break the line must go high again first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (brk) begin
                rx_busy <= 1'b0;
            end else if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= BW'(P / 2 - 1);
                    rx_idx  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= BW'(P - 1);
                rx_idx <= rx_idx + 4'd1;
                if (rx_idx == 4'd0) begin
                    if (rx_s2)
                        rx_busy <= 1'b0;
                end else if (rx_idx == 4'd9) begin
                    rx_busy  <= 1'b0;
                    rx_valid <= rx_s2;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            uart_tx <= 1'b1;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_sr   <= '1;
        end else if (!tx_busy) begin
            uart_tx <= 1'b1;
            if (tx_start) begin
                tx_busy <= 1'b1;
                tx_sr   <= {1'b1, sr_i};
                uart_tx <= 1'b0;
                tx_cnt  <= BW'(P - 1);
                tx_idx  <= '0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            tx_cnt <= BW'(P - 1);
            if (tx_idx == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                uart_tx <= tx_sr[0];
                tx_sr   <= {1'b1, tx_sr[8:1]};
                tx_idx  <= tx_idx + 4'd1;
            end
        end
    end

    // Mode-0 shifter: MISO sampled as SCK rises, MOSI advanced as SCK falls.
    always_ff @(posedge clk) begin
        if (rst || brk) begin
            spi_busy  <= 1'b0;
            spi_sck   <= 1'b0;
            spi_so    <= 1'b0;
            spi_done  <= 1'b0;
            spi_cnt   <= '0;
            spi_edges <= '0;
            sr_o      <= '0;
            sr_i      <= '0;
        end else begin
            spi_done <= 1'b0;
            if (!spi_busy) begin
                if (spi_start) begin
                    spi_busy  <= 1'b1;
                    sr_o      <= spi_byte[6:0];
                    spi_so    <= spi_byte[7];
                    spi_cnt   <= SW'(SPI_HALF - 1);
                    spi_edges <= '0;
                end
            end else if (spi_cnt != '0) begin
                spi_cnt <= spi_cnt - 1'b1;
            end else begin
                spi_cnt   <= SW'(SPI_HALF - 1);
                spi_edges <= spi_edges + 4'd1;
                spi_sck   <= !spi_sck;
                if (!spi_sck) begin
                    sr_i <= {sr_i[6:0], spi_si};
                end else if (spi_edges == 4'd15) begin
                    spi_busy <= 1'b0;
                    spi_done <= 1'b1;
                    spi_so   <= 1'b0;
                end else begin
                    spi_so <= sr_o[6];
                    sr_o   <= {sr_o[5:0], 1'b0};
                end
            end
        end
    end

    // Chip select release is delayed so it rises one half period after the final SCK fall.
    always_ff @(posedge clk) begin
        if (rst || brk) begin
            spi_ss    <= 1'b1;
            hold_busy <= 1'b0;
            hold_cnt  <= '0;
        end else if (ss_fall) begin
            spi_ss <= 1'b0;
        end else if (ss_end) begin
            hold_busy <= 1'b1;
            hold_cnt  <= SW'(SPI_HALF - 2);
        end else if (hold_busy) begin
            if (hold_cnt == '0) begin
                spi_ss    <= 1'b1;
                hold_busy <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tx_len <= '0;
            rx_len <= '0;
        end else begin
            state  <= state_n;
            tx_len <= tx_len_n;
            rx_len <= rx_len_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_len_n  = tx_len;
        rx_len_n  = rx_len;
        spi_start = 1'b0;
        spi_byte  = 8'h00;
        tx_start  = 1'b0;
        ss_fall   = 1'b0;
        ss_end    = 1'b0;
        if (brk && state != BOOTED) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && rx_shift == 8'h00)
                        state_n = BOOTED;
                    else if (rx_valid && rx_shift == 8'h01)
                        state_n = TXL0;
                end
                TXL0: if (rx_valid) begin
                    tx_len_n = {tx_len[15:8], rx_shift};
                    state_n  = TXL1;
                end
                TXL1: if (rx_valid) begin
                    tx_len_n = {rx_shift, tx_len[7:0]};
                    state_n  = RXL0;
                end
                RXL0: if (rx_valid) begin
                    rx_len_n = {rx_len[15:8], rx_shift};
                    state_n  = RXL1;
                end
                RXL1: if (rx_valid) begin
                    rx_len_n = {rx_shift, rx_len[7:0]};
                    if (tx_len != 16'd0) begin
                        state_n = TXDATA;
                        ss_fall = 1'b1;
                    end else if (rx_len_n != 16'd0) begin
                        state_n = RXDATA;
                        ss_fall = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                TXDATA: begin
                    if (spi_done) begin
                        tx_len_n = tx_len - 16'd1;
                        if (tx_len == 16'd1) begin
                            if (rx_len != 16'd0) begin
                                state_n = RXDATA;
                            end else begin
                                state_n = IDLE;
                                ss_end  = 1'b1;
                            end
                        end
                    end else if (rx_valid && !spi_busy) begin
                        spi_start = 1'b1;
                        spi_byte  = rx_shift;
                    end
                end
                RXDATA: begin
                    // The captured byte goes straight to the idle transmitter; the next
                    // shift waits until that byte has left.
                    if (spi_done) begin
                        tx_start = 1'b1;
                        rx_len_n = rx_len - 16'd1;
                        if (rx_len == 16'd1) begin
                            state_n = IDLE;
                            ss_end  = 1'b1;
                        end
                    end else if (!spi_busy && !tx_busy) begin
                        spi_start = 1'b1;
                    end
                end
                BOOTED: ;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bootloader.sv
// Scoreboard bench for uart_bootloader: stimulus pushes expected SPI bytes,
// transfer lengths and UART replies; independent monitors pop and compare.
module tb_uart_bootloader;

    localparam int P        = 16;
    localparam int SPI_HALF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       uart_tx;
    logic       spi_sck;
    logic       spi_so;
    logic       spi_si;
    logic       spi_ss;
    logic       boot;
    logic [1:0] boot_sel;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_spi[$];
    int         exp_frame[$];
    logic [7:0] exp_uart[$];

    logic [7:0] flash_resp [0:7];
    logic [7:0] flash_bit = 8'd0;

    int cyc         = 0;
    int ss_falls    = 0;
    int stray_rises = 0;

    uart_bootloader #(
        .CLK_FREQ     (1000000),
        .UART_BAUDRATE(62500),
        .SPI_HALF     (SPI_HALF),
        .BREAK_BITS   (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .spi_sck (spi_sck),
        .spi_so  (spi_so),
        .spi_si  (spi_si),
        .spi_ss  (spi_ss),
        .boot    (boot),
        .boot_sel(boot_sel)
    );

    always #5 clk = ~clk;

    // Flash model: presents response bits MSB first, advancing after each SCK rise.
    always @(posedge spi_sck or posedge spi_ss) begin
        if (spi_ss)
            flash_bit <= 8'd0;
        else
            flash_bit <= flash_bit + 8'd1;
    end
    assign spi_si = flash_resp[flash_bit[5:3]][~flash_bit[2:0]];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (P) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (P) @(negedge clk);
    endtask

    task automatic sendCommand(input logic [7:0] tl, input logic [7:0] rl, input logic [7:0] d0,
                               input logic [7:0] d1, input bit two_data);
        applyStimulus(8'h01);
        applyStimulus(tl);
        applyStimulus(8'h00);
        applyStimulus(rl);
        applyStimulus(8'h00);
        applyStimulus(d0);
        if (two_data)
            applyStimulus(d1);
    endtask

    task automatic setFlash(input bit use_id);
        for (int i = 0; i < 8; i++)
            flash_resp[i] = 8'h00;
        if (use_id) begin
            flash_resp[2] = 8'hEF;
            flash_resp[3] = 8'h40;
            flash_resp[4] = 8'h18;
        end
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_spi_left"}, exp_spi.size(), 0);
        checkOutput({tag, "_frame_left"}, exp_frame.size(), 0);
        checkOutput({tag, "_uart_left"}, exp_uart.size(), 0);
        checkOutput({tag, "_ss_idle"}, spi_ss, 1);
    endtask

    // UART monitor: decodes each transmitted frame at mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                repeat (P / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (P) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (P) @(negedge clk);
                checkOutput("uart_stop_bit", uart_tx, 1);
                checkOutput("uart_byte_expected", int'(exp_uart.size() != 0), 1);
                if (exp_uart.size() != 0)
                    checkOutput("uart_byte", b, exp_uart.pop_front());
            end
        end
    end

    // SPI monitor: assembles MOSI bytes per select window and checks select timing.
    initial begin
        logic       ss_q  = 1'b1;
        logic       sck_q = 1'b0;
        logic [7:0] sh    = 8'h00;
        int bitn = 0, win_rises = 0, t_fall = 0, t_r1 = 0, t_lf = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ss_q && spi_ss === 1'b0) begin
                ss_falls++;
                t_fall    = cyc;
                win_rises = 0;
                bitn      = 0;
            end
            if (!sck_q && spi_sck === 1'b1) begin
                if (spi_ss === 1'b0) begin
                    if (win_rises == 0)
                        t_r1 = cyc;
                    win_rises++;
                    sh = {sh[6:0], spi_so};
                    bitn++;
                    if (bitn == 8) begin
                        bitn = 0;
                        checkOutput("spi_byte_expected", int'(exp_spi.size() != 0), 1);
                        if (exp_spi.size() != 0)
                            checkOutput("spi_mosi_byte", sh, exp_spi.pop_front());
                    end
                end else begin
                    stray_rises++;
                end
            end
            if (sck_q && spi_sck === 1'b0 && spi_ss === 1'b0)
                t_lf = cyc;
            if (!ss_q && spi_ss === 1'b1) begin
                checkOutput("spi_frame_expected", int'(exp_frame.size() != 0), 1);
                if (exp_frame.size() != 0)
                    checkOutput("spi_frame_rises", win_rises, exp_frame.pop_front());
                checkOutput("ss_lead_enough", int'((t_r1 - t_fall) >= SPI_HALF), 1);
                checkOutput("ss_tail_cycles", cyc - t_lf, SPI_HALF);
            end
            ss_q  = spi_ss;
            sck_q = spi_sck;
        end
    end

    initial begin
        int falls_before;
        setFlash(1'b0);
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset idle");
        for (int i = 0; i < 10; i++) begin
            repeat (P) @(negedge clk);
            checkOutput("idle_uart_tx", uart_tx, 1);
            checkOutput("idle_spi_ss", spi_ss, 1);
            checkOutput("idle_spi_sck", spi_sck, 0);
            checkOutput("idle_boot", boot, 0);
        end
        checkOutput("reset_spi_so", spi_so, 0);
        checkOutput("reset_boot_sel", boot_sel, 1);

        $display("[TB] read with MISO low");
        exp_spi.push_back(8'h9F);
        for (int i = 0; i < 6; i++) exp_spi.push_back(8'h00);
        exp_frame.push_back(56);
        for (int i = 0; i < 5; i++) exp_uart.push_back(8'h00);
        sendCommand(8'h02, 8'h05, 8'h9F, 8'h00, 1'b1);
        repeat (2000) @(negedge clk);
        checkDrained("s2");
        checkOutput("s2_ss_falls", ss_falls, 1);

        $display("[TB] read JEDEC id");
        setFlash(1'b1);
        exp_spi.push_back(8'h9F);
        for (int i = 0; i < 6; i++) exp_spi.push_back(8'h00);
        exp_frame.push_back(56);
        exp_uart.push_back(8'hEF);
        exp_uart.push_back(8'h40);
        exp_uart.push_back(8'h18);
        exp_uart.push_back(8'h00);
        exp_uart.push_back(8'h00);
        sendCommand(8'h02, 8'h05, 8'h9F, 8'h00, 1'b1);
        repeat (2000) @(negedge clk);
        checkDrained("s3");

        $display("[TB] break mid-header");
        falls_before = ss_falls;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        uart_rx = 1'b0;
        repeat (19 * P) @(negedge clk);
        uart_rx = 1'b1;
        repeat (P) @(negedge clk);
        checkOutput("brk_ss_falls", ss_falls, falls_before);
        checkOutput("brk_stray_sck", stray_rises, 0);
        checkOutput("brk_spi_ss", spi_ss, 1);
        checkOutput("brk_boot", boot, 0);
        exp_spi.push_back(8'h9F);
        for (int i = 0; i < 6; i++) exp_spi.push_back(8'h00);
        exp_frame.push_back(56);
        exp_uart.push_back(8'hEF);
        exp_uart.push_back(8'h40);
        exp_uart.push_back(8'h18);
        exp_uart.push_back(8'h00);
        exp_uart.push_back(8'h00);
        sendCommand(8'h02, 8'h05, 8'h9F, 8'h00, 1'b1);
        repeat (2000) @(negedge clk);
        checkDrained("s4");

        $display("[TB] write only");
        falls_before = ss_falls;
        exp_spi.push_back(8'hAB);
        exp_frame.push_back(8);
        sendCommand(8'h01, 8'h00, 8'hAB, 8'h00, 1'b0);
        repeat (400) @(negedge clk);
        checkDrained("s5");
        checkOutput("s5_ss_falls", ss_falls - falls_before, 1);

        $display("[TB] warm boot");
        applyStimulus(8'h00);
        repeat (2) @(negedge clk);
        checkOutput("boot_set", boot, 1);
        checkOutput("boot_sel_value", boot_sel, 1);
        falls_before = ss_falls;
        sendCommand(8'h01, 8'h00, 8'hAB, 8'h00, 1'b0);
        repeat (400) @(negedge clk);
        checkOutput("booted_ss_falls", ss_falls, falls_before);
        checkOutput("booted_boot_held", boot, 1);
        checkOutput("final_stray_sck", stray_rises, 0);
        checkDrained("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bootloader.md
# uart_bootloader

UART-to-SPI bridge and warm-boot trigger for the FPGA bootloader image. A host on a 8N1 UART link issues framed SPI transactions against the configuration flash and reads back the results over UART. A single command releases the FPGA into the user image through a warm-boot request. The block sits between the board UART pins, the flash SPI pins, and the device warm-boot primitive.

## Interface
- CLK_FREQ, 12000000: clk frequency in Hz.
- UART_BAUDRATE, 115200: UART bit rate; bit period P = CLK_FREQ/UART_BAUDRATE cycles (integer divide).
- SPI_HALF, 6: clk cycles per SCK half period.
- BREAK_BITS, 16: number of consecutive low bit periods on uart_rx that counts as a break.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- uart_rx  in  1  UART receive line, idle high, asynchronous to clk.
- uart_tx  out  1  UART transmit line, idle high.
- spi_sck  out  1  SPI clock, mode 0 (idles low).
- spi_so  out  1  SPI data to flash (MOSI).
- spi_si  in  1  SPI data from flash (MISO).
- spi_ss  out  1  flash chip select, active low.
- boot  out  1  warm-boot request; latched high once set.
- boot_sel  out  2  warm-boot image select; constant 2'b01.

## Operation
- UART RX path
  - uart_rx passes through a 2-flop synchronizer.
  - A start bit is a high-to-low edge. Data bits are sampled at mid-bit, 8 data bits, LSB first, then the stop bit is sampled.
  - A byte with a stop bit of 0 (framing error) is discarded and never delivered.
- Break
  - uart_rx held low for at least BREAK_BITS*P consecutive cycles raises a break.
  - On break, the command FSM returns to IDLE, any SPI shift in progress stops, spi_ss goes high and spi_sck goes low.
  - A UART TX byte already in progress finishes.
  - After a break, the receiver waits for uart_rx to return high before accepting a new start bit.
  - Because the zero byte seen during a break is a framing error, a break never triggers boot.
- Command FSM states: IDLE, TXL0, TXL1, RXL0, RXL1, TXDATA, RXDATA, BOOTED.
  - IDLE:
    - byte 0x00 → BOOTED;
    - byte 0x01 → TXL0;
    - any other byte is ignored.
  - TXL0/TXL1 capture tx_len as 16 bits, little endian. RXL0/RXL1 capture rx_len the same way.
  - After RXL1:
    - tx_len>0 → TXDATA;
    - tx_len=0 and rx_len>0 → RXDATA;
    - both 0 → IDLE, with no spi_ss activity.
  - TXDATA:
    - spi_ss goes low before the first data byte is shifted.
    - Each received UART byte is shifted out on spi_so MSB first. MISO is not captured in this phase.
    - After tx_len bytes: rx_len>0 → RXDATA; otherwise spi_ss goes high and the FSM returns to IDLE.
  - RXDATA:
    - Shift 8 bits with spi_so=0, sampling spi_si on SCK rising edges, MSB first.
    - Queue the captured byte to the UART TX. Start the next SPI byte only once the UART TX is idle, so one byte of buffering suffices.
    - After rx_len bytes, spi_ss goes high and the FSM returns to IDLE.
    - UART bytes received during RXDATA are discarded.
  - BOOTED: boot=1 is held until rst. All further UART input is ignored.
- SPI is mode 0.
  - spi_so changes while SCK is low.
  - SCK high and low phases are SPI_HALF cycles each.
- UART TX: 8N1, LSB first, P cycles per bit.

## Timing
- Reset values: uart_tx=1, spi_ss=1, spi_sck=0, spi_so=0, boot=0. The FSM resets to IDLE and both UART engines reset to idle.
- RX byte valid: 1-cycle strobe at the stop-bit mid-sample, about 9.5P cycles after the start edge, plus 2 cycles of synchronizer delay.
- TXDATA byte latency:
  - The SPI shift starts no more than 2 cycles after the RX strobe.
  - The shift takes 16*SPI_HALF cycles.
  - spi_ss stays low continuously between bytes of one transfer.
- spi_ss falls at least SPI_HALF cycles before the first SCK rise.
- spi_ss rises SPI_HALF cycles after the last SCK fall.
- RXDATA: the UART start bit for a byte begins no more than 2 cycles after its 8th SCK fall.
- rst mid-operation overrides everything on the next clk edge.
- A break has priority over a simultaneous RX strobe.

## Test plan
- Reset, then 10P idle: uart_tx=1, spi_ss=1, spi_sck=0, boot=0 throughout.
- Send 01 02 00 05 00 9F 00 with spi_si tied 0:
  - spi_ss low exactly once, for 56 SCK rising edges;
  - spi_so carries 0x9F then 0x00, then 40 zero bits;
  - uart_tx emits five 0x00 bytes;
  - spi_ss then high.
- Same command with a flash model returning EF 40 18 00 00 after 9F 00: uart_tx emits EF 40 18 00 00 in order.
- Send 01 02 00, then hold uart_rx low for 19P, release, and wait P:
  - no SCK edges occur and spi_ss stays 1;
  - boot stays 0;
  - repeating the full 7-byte command then behaves exactly as in the second scenario.
- Send 01 01 00 00 00 AB: spi_so shifts 0xAB (8 SCK edges), spi_ss pulses low once, no uart_tx activity.
- Send 00 from IDLE: boot=1 and boot_sel=01 after the stop bit. A following 01 command produces no SPI activity.
